// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, condition codes and PC-stage state encoding
package cpu_pkg;

    localparam logic [4:0] OP_B    = 5'h0C;
    localparam logic [4:0] OP_BR   = 5'h0D;
    localparam logic [4:0] OP_CALL = 5'h0E;
    localparam logic [4:0] OP_RET  = 5'h0F;
    localparam logic [4:0] OP_HLT  = 5'h10;

    typedef enum logic [2:0] {
        CC_NE = 3'd0,
        CC_EQ = 3'd1,
        CC_GT = 3'd2,
        CC_LT = 3'd3,
        CC_GE = 3'd4,
        CC_LE = 3'd5,
        CC_OV = 3'd6,
        CC_AL = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // flag is packed {z, v, n}
    function automatic logic cond_met(input cond_e cc, input logic [2:0] flag);
        logic z, v, n;
        z = flag[2];
        v = flag[1];
        n = flag[0];
        case (cc)
            CC_NE:   return !z;
            CC_EQ:   return z;
            CC_GT:   return !z && !n;
            CC_LT:   return n;
            CC_GE:   return z || !n;
            CC_LE:   return z || n;
            CC_OV:   return v;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] top_idx;

    // ptr_q always points at the next free slot, so the top sits just behind it
    assign top_idx = ptr_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch PC, branch resolution, squash window, return stack and halt
module pc_ctrl
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [4:0]  ex_opcode,
    input  logic [2:0]  ex_cond,
    input  logic [15:0] ex_pc,
    input  logic [8:0]  ex_off,
    input  logic [15:0] ex_reg,
    input  logic [2:0]  flag,
    output logic [15:0] pc,
    output logic        flush,
    output logic        taken,
    output logic        halted,
    output logic        ras_err
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic        ras_err_q, ras_err_d;

    logic        resolve;
    logic        is_b, is_br, is_call, is_ret, is_hlt;
    logic [15:0] ret_addr, rel_tgt, target;
    logic        ras_push, ras_pop, ras_empty;
    logic [15:0] ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_count;

    assign resolve  = ex_valid && !stall && (state_q == ST_RUN);
    assign is_b     = (ex_opcode == OP_B);
    assign is_br    = (ex_opcode == OP_BR);
    assign is_call  = (ex_opcode == OP_CALL);
    assign is_ret   = (ex_opcode == OP_RET);
    assign is_hlt   = (ex_opcode == OP_HLT);
    assign ret_addr = ex_pc + 16'd1;
    assign rel_tgt  = ret_addr + {{7{ex_off[8]}}, ex_off};
    assign ras_push = resolve && is_call;
    assign ras_pop  = resolve && is_ret && (ras_count != '0);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (16)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ret_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .count     (ras_count)
    );

    always_comb begin
        taken  = 1'b0;
        target = rel_tgt;
        if (resolve) begin
            if (is_b) begin
                taken = cond_met(cond_e'(ex_cond), flag);
            end else if (is_br) begin
                taken  = cond_met(cond_e'(ex_cond), flag);
                target = ex_reg;
            end else if (is_call) begin
                taken = 1'b1;
            end else if (is_ret) begin
                taken  = 1'b1;
                target = ras_empty ? RESET_PC : ras_top;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fcnt_d    = fcnt_q;
        ras_err_d = ras_err_q;
        if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (taken) begin
                        pc_d    = target;
                        fcnt_d  = FLUSH_LOAD;
                        // a one-cycle window is covered entirely by the resolve cycle
                        state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                        if (is_ret && ras_empty) begin
                            ras_err_d = 1'b1;
                        end
                    end else if (resolve && is_hlt) begin
                        pc_d    = ret_addr;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
                ST_FLUSH: begin
                    pc_d = pc_q + 16'd1;
                    if (fcnt_q <= 2'd1) begin
                        fcnt_d  = 2'd0;
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d = fcnt_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            fcnt_q    <= 2'd0;
            ras_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fcnt_q    <= fcnt_d;
            ras_err_q <= ras_err_d;
        end
    end

    assign pc      = pc_q;
    assign flush   = taken || (state_q != ST_RUN);
    assign halted  = (state_q == ST_HALT);
    assign ras_err = ras_err_q;

endmodule
